// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: one outstanding data-memory transaction per request,
// word-aligned address with byte mask, pipeline stall until completion, extended load result.
module dmem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [3:0]            req_load_sel,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  dmem_read,
    output logic                  dmem_write,
    output logic [ADDR_WIDTH-1:0] dmem_address,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_wmask,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_resp,
    output logic                  stall,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic                  misaligned,
    output logic [1:0]            o_dbg_state
);

    localparam logic [3:0] SEL_LB  = 4'b0101;
    localparam logic [3:0] SEL_LBU = 4'b0110;
    localparam logic [3:0] SEL_LH  = 4'b0111;
    localparam logic [3:0] SEL_LHU = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wmask;
    logic [3:0]            r_load_sel;
    logic [1:0]            r_off;
    logic                  r_read;
    logic                  r_write;
    logic                  r_mis;
    logic [31:0]           r_load_data;

    logic                  w_new_req;
    size_t                 w_size;
    logic                  w_misaligned;
    logic [3:0]            w_wmask;
    logic [31:0]           w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ext;

    assign w_new_req = req_valid & (req_read | req_write);

    // Access width comes from the load select when reading (read wins over write).
    always_comb begin
        w_size = SZ_WORD;
        if (req_read) begin
            case (req_load_sel)
                SEL_LB, SEL_LBU: w_size = SZ_BYTE;
                SEL_LH, SEL_LHU: w_size = SZ_HALF;
                default:         w_size = SZ_WORD;
            endcase
        end else begin
            case (req_funct3)
                3'b000:  w_size = SZ_BYTE;
                3'b001:  w_size = SZ_HALF;
                default: w_size = SZ_WORD;
            endcase
        end
    end

    assign w_misaligned = ((w_size == SZ_HALF) & req_addr[0]) |
                          ((w_size == SZ_WORD) & (|req_addr[1:0]));

    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = 32'h0;
        if (!req_read) begin
            case (w_size)
                SZ_BYTE: begin
                    w_wmask = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                SZ_HALF: begin
                    w_wmask = 4'b0011 << {req_addr[1], 1'b0};
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_wmask = 4'b1111;
                    w_wdata = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
    end

    assign w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (r_load_sel)
            SEL_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
            SEL_LBU: w_ext = {24'h0, w_byte};
            SEL_LH:  w_ext = {{16{w_half[15]}}, w_half};
            SEL_LHU: w_ext = {16'h0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_new_req) begin
                    w_next_state = w_misaligned ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dmem_resp) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_read   = (r_state == S_ACCESS) & r_read;
        dmem_write  = (r_state == S_ACCESS) & r_write;
        stall       = ((r_state == S_IDLE) & w_new_req) | (r_state == S_ACCESS);
        done        = (r_state == S_DONE);
        misaligned  = (r_state == S_DONE) & r_mis;
        o_dbg_state = r_state;
    end

    // Transaction fields are only captured in IDLE so they stay frozen through ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_wmask     <= 4'b0000;
            r_load_sel  <= 4'b0000;
            r_off       <= 2'b00;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_mis       <= 1'b0;
            r_load_data <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_new_req) begin
                        if (w_misaligned) begin
                            r_mis       <= 1'b1;
                            r_load_data <= 32'h0;
                        end else begin
                            r_mis      <= 1'b0;
                            r_addr     <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            r_wdata    <= w_wdata;
                            r_wmask    <= w_wmask;
                            r_load_sel <= req_load_sel;
                            r_off      <= req_addr[1:0];
                            r_read     <= req_read;
                            r_write    <= req_write & ~req_read;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_resp) begin
                        r_load_data <= r_read ? w_ext : 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_address = r_addr;
    assign dmem_wdata   = r_wdata;
    assign dmem_wmask   = r_wmask;
    assign load_data    = r_load_data;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit: table of directed requests, async reset mid-access,
// and randomized requests checked against an arithmetic reference model.
module tb_dmem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [3:0]  req_load_sel;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          k;
        logic        mis;
        logic [31:0] load;
        logic [3:0]  mask;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[$];

    dmem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .req_load_sel (req_load_sel),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_wmask   (dmem_wmask),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .stall        (stall),
        .done         (done),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .o_dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [3:0] sel, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int k, input bit mis, input logic [31:0] load,
                                input logic [3:0] mask, input logic [31:0] wd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.sel = sel; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.k = k; v.mis = mis;
        v.load = load; v.mask = mask; v.wd = wd;
        return v;
    endfunction

    // Reference model: access size in bytes, alignment by modulo, extension by arithmetic.
    function automatic void model(inout vec_t v);
        longint size;
        bit     sgn;
        longint off;
        longint val;
        longint a;
        size = 4;
        sgn  = 0;
        a    = longint'(v.addr);
        if (v.rd) begin
            case (v.sel)
                4'b0101: begin size = 1; sgn = 1; end
                4'b0110: size = 1;
                4'b0111: begin size = 2; sgn = 1; end
                4'b1000: size = 2;
                default: size = 4;
            endcase
        end else begin
            case (v.f3)
                3'd0:    size = 1;
                3'd1:    size = 2;
                default: size = 4;
            endcase
        end
        off   = a % 4;
        v.mis = (a % size) != 0;
        v.load = 32'h0;
        v.mask = 4'h0;
        v.wd   = 32'h0;
        if (!v.mis) begin
            if (v.rd) begin
                val = (longint'(v.rdata) >> (8 * off)) % (longint'(1) << (8 * size));
                if (sgn && val >= (longint'(1) << (8 * size - 1)))
                    val = val - (longint'(1) << (8 * size));
                v.load = val[31:0];
            end else begin
                val    = ((longint'(1) << size) - 1) << off;
                v.mask = val[3:0];
                val    = longint'(v.wdata) % (longint'(1) << (8 * size));
                if (size == 1)      val = val * 64'h0101_0101;
                else if (size == 2) val = val * 64'h0001_0001;
                v.wd = val[31:0];
            end
        end
    endfunction

    // Drives one request from the IDLE cycle (cycle 0) until done is seen or the budget runs out.
    task automatic run_req(input vec_t v, input string tag);
        int          stall_n = 0;
        int          rd_n = 0;
        int          wr_n = 0;
        int          done_at = -1;
        logic        mis_seen = 1'b0;
        logic [31:0] ld_seen = 32'hX;
        logic [31:0] exp_addr;
        int          exp_done;
        exp_addr = v.addr - (v.addr % 4);
        exp_done = v.mis ? 1 : v.k + 1;
        for (int c = 0; c <= v.k + 4 && done_at < 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                req_valid    = 1'b1;
                req_read     = v.rd;
                req_write    = v.wr;
                req_funct3   = v.f3;
                req_load_sel = v.sel;
                req_addr     = v.addr;
                req_wdata    = v.wdata;
            end
            dmem_resp  = (c == 0) || (v.mis ? (c == 1) : (c == v.k));
            dmem_rdata = dmem_resp ? v.rdata : $urandom();
            @(negedge clk);
            stall_n += int'(stall);
            rd_n    += int'(dmem_read);
            wr_n    += int'(dmem_write);
            if (dmem_read || dmem_write) begin
                check($sformatf("%s addr c%0d", tag, c), dmem_address, exp_addr);
                check($sformatf("%s wmask c%0d", tag, c), {28'h0, dmem_wmask}, {28'h0, v.mask});
                if (!v.rd)
                    check($sformatf("%s wdata c%0d", tag, c), dmem_wdata, v.wd);
            end
            if (done) begin
                done_at  = c;
                mis_seen = misaligned;
                ld_seen  = load_data;
            end
        end
        dmem_resp = 1'b0;
        check({tag, " stall_cycles"}, stall_n, v.mis ? 1 : v.k + 1);
        check({tag, " read_cycles"}, rd_n, (v.mis || !v.rd) ? 0 : v.k);
        check({tag, " write_cycles"}, wr_n, (v.mis || v.rd || !v.wr) ? 0 : v.k);
        check({tag, " done_cycle"}, done_at, exp_done);
        check({tag, " misaligned"}, {31'h0, mis_seen}, {31'h0, v.mis});
        check({tag, " load_data"}, ld_seen, v.load);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_read     = 1'b0;
        req_write    = 1'b0;
        req_funct3   = 3'd0;
        req_load_sel = 4'd0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        dmem_rdata   = 32'h0;
        dmem_resp    = 1'b0;

        //         rd wr f3  sel      addr          wdata         rdata         k mis load          mask     wd
        tbl.push_back(mk(1, 0, 3'd0, 4'b0101, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 0, 32'hFFFF_FF80, 4'b0000, 32'h0));
        tbl.push_back(mk(1, 0, 3'd0, 4'b1000, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 2, 0, 32'h0000_BEEF, 4'b0000, 32'h0));
        tbl.push_back(mk(1, 0, 3'd0, 4'b0111, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 1, 0, 32'hFFFF_BEEF, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 1, 3'd0, 4'b0000, 32'h0000_3001, 32'h1234_56AB, 32'h0,        1, 0, 32'h0,         4'b0010, 32'hABAB_ABAB));
        tbl.push_back(mk(1, 0, 3'd0, 4'b0011, 32'h0000_4002, 32'h0,        32'h0,         1, 1, 32'h0,         4'b0000, 32'h0));
        tbl.push_back(mk(0, 1, 3'd1, 4'b0000, 32'h0000_3003, 32'h5555_5555, 32'h0,        1, 1, 32'h0,         4'b0000, 32'h0));
        tbl.push_back(mk(0, 1, 3'd2, 4'b0000, 32'h0000_5000, 32'hCAFE_F00D, 32'h0,        3, 0, 32'h0,         4'b1111, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 3'd0, 4'b0110, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2, 0, 32'h0000_0080, 4'b0000, 32'h0));
        tbl.push_back(mk(1, 0, 3'd0, 4'b0011, 32'h0000_6000, 32'h0,        32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 4'b0000, 32'h0));
        tbl.push_back(mk(1, 1, 3'd2, 4'b0110, 32'h0000_7001, 32'h1122_3344, 32'h0000_AB00, 2, 0, 32'h0000_00AB, 4'b0000, 32'h0));
        tbl.push_back(mk(1, 0, 3'd0, 4'b0000, 32'h0000_8002, 32'h0,        32'h0,         1, 1, 32'h0,         4'b0000, 32'h0));
        tbl.push_back(mk(1, 0, 3'd0, 4'b0000, 32'h0000_8000, 32'h0,        32'h1234_5678, 1, 0, 32'h1234_5678, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 1, 3'd1, 4'b0000, 32'h0000_9002, 32'h0000_BEEF, 32'h0,        2, 0, 32'h0,         4'b1100, 32'hBEEF_BEEF));
        tbl.push_back(mk(1, 0, 3'd0, 4'b0101, 32'h0000_A001, 32'h0,        32'h0000_7F00, 1, 0, 32'h0000_007F, 4'b0000, 32'h0));
        tbl.push_back(mk(1, 0, 3'd0, 4'b0111, 32'h0000_B001, 32'h0,        32'h0,         1, 1, 32'h0,         4'b0000, 32'h0));
        tbl.push_back(mk(0, 1, 3'd0, 4'b0000, 32'h0000_C003, 32'h0000_005A, 32'h0,        1, 0, 32'h0,         4'b1000, 32'h5A5A_5A5A));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst dmem_read", {31'h0, dmem_read}, 32'h0);
        check("rst dmem_write", {31'h0, dmem_write}, 32'h0);
        check("rst dmem_address", dmem_address, 32'h0);
        check("rst dmem_wdata", dmem_wdata, 32'h0);
        check("rst dmem_wmask", {28'h0, dmem_wmask}, 32'h0);
        check("rst stall", {31'h0, stall}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check("rst load_data", load_data, 32'h0);
        check("rst misaligned", {31'h0, misaligned}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table, issued back to back.
        for (int i = 0; i < tbl.size(); i++)
            run_req(tbl[i], $sformatf("vec%0d", i));
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("idle after table done", {31'h0, done}, 32'h0);
        check("idle after table stall", {31'h0, stall}, 32'h0);

        // Reset asserted in the middle of a store access.
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'd2;
        req_load_sel = 4'd0; req_addr = 32'h0000_5000; req_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rstmid write before", {31'h0, dmem_write}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rstmid write async", {31'h0, dmem_write}, 32'h0);
        check("rstmid read async", {31'h0, dmem_read}, 32'h0);
        check("rstmid stall async", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_resp = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("rstmid no done c%0d", c), {31'h0, done}, 32'h0);
            check($sformatf("rstmid no strobe c%0d", c), {30'h0, dmem_read, dmem_write}, 32'h0);
            @(posedge clk);
            #1 dmem_resp = 1'b0;
        end
        run_req(tbl[0], "after_rst lb");

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            logic [3:0] sels[7];
            sels = '{4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b0000, 4'b1111};
            v.rd    = 1'($urandom_range(0, 1));
            v.wr    = v.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            v.f3    = 3'($urandom_range(0, 2));
            v.sel   = sels[$urandom_range(0, 6)];
            v.addr  = $urandom();
            v.wdata = $urandom();
            v.rdata = $urandom();
            v.k     = $urandom_range(1, 4);
            model(v);
            run_req(v, $sformatf("rand%0d", i));
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("final idle done", {31'h0, done}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
